seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter: MAX_LEN, default 8, maximum pattern length in bits.
REQ-002 Parameter: CNT_W, default 8, match-counter width.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: cfg_we  input  1  config write strobe; accepted only in IDLE or ERR.
REQ-006 Port: cfg_pattern  input  MAX_LEN  pattern; bit [len-1] received first, bit [0] last.
REQ-007 Port: cfg_len  input  4  pattern length; legal range 2..MAX_LEN.
REQ-008 Port: cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port: cfg_target  input  CNT_W  match count that ends a run; legal range 1..2^CNT_W-1.
REQ-010 Port: start  input  1  one-cycle pulse; begins a run.
REQ-011 Port: stop  input  1  one-cycle pulse; aborts a run.
REQ-012 Port: seq_valid  input  1  seq_in is valid this cycle.
REQ-013 Port: seq_in  input  1  serial data bit.
REQ-014 Port: detected  output  1  one-cycle pulse per match.
REQ-015 Port: match_count  output  CNT_W  matches counted in the current or last run.
REQ-016 Port: busy  output  1  high while in RUN.
REQ-017 Port: done  output  1  high while in DONE.
REQ-018 Port: err_cfg  output  1  high while in ERR.
REQ-019 Port: state_out  output  2  current state encoding, for debug.

Function
REQ-020 The FSM SHALL have four states: IDLE=0, RUN=1, DONE=2, ERR=3.
REQ-021 Config registers SHALL load on cfg_we in IDLE/ERR and hold otherwise; cfg_we in RUN/DONE SHALL be ignored.
REQ-022 On cfg_we in ERR, the FSM SHALL go to IDLE.
REQ-023 On start in IDLE or DONE with legal config, the FSM SHALL go to RUN and clear match_count, history and fill counter at the same edge.
REQ-024 On start with illegal config (cfg_len<2, cfg_len>MAX_LEN, or target=0), the FSM SHALL go to ERR with match_count unchanged.
REQ-025 start while in RUN or ERR SHALL be ignored.
REQ-026 Bits SHALL be sampled only in RUN with seq_valid=1; history SHALL shift as {hist[MAX_LEN-2:0], seq_in}; the fill counter SHALL increment and saturate at cfg_len.
REQ-027 A match SHALL occur when the post-shift hist[len-1:0] == pattern[len-1:0] and the post-shift fill count equals cfg_len.
REQ-028 On a match: detected=1 for exactly the cycle after the sampling edge, and match_count increments at that edge.
REQ-029 Non-overlap mode: a match SHALL clear the fill counter, so the next match needs cfg_len fresh bits.
REQ-030 Overlap mode: a match SHALL leave the fill counter at cfg_len.
REQ-031 When a match makes match_count equal cfg_target, the FSM SHALL enter DONE at that edge; detected still pulses that cycle.
REQ-032 In DONE, match_count SHALL hold and bits SHALL be ignored.
REQ-033 On stop in RUN, the FSM SHALL go to IDLE with match_count held; a simultaneous bit SHALL be discarded, and stop wins over a match.
REQ-034 stop in any other state SHALL go to IDLE.
REQ-035 seq_valid=0 cycles SHALL leave history, fill and count unchanged; gaps do not break a pattern.
REQ-036 busy, done, err_cfg and state_out SHALL be decoded directly from the state register; detected SHALL be registered.

Reset
REQ-037 When rst=1 at an edge, at any time including mid-run: state=IDLE, detected=0, match_count=0, history=0, fill=0, busy=done=err_cfg=0.
REQ-038 Reset SHALL set config registers to pattern=0b101, len=3, overlap=0, target=1.
REQ-039 rst SHALL override every other input in the same cycle.

Verification
REQ-040 Config 101/len3/overlap=0/target=8; stream 00110001010101 with seq_valid=1 -> detected pulses after bit indices 9 and 13; match_count=2; busy stays 1.
REQ-041 Same stream with overlap=1 -> pulses after indices 9, 11 and 13; match_count=3.
REQ-042 Overlap=1, target=2, same stream -> DONE entered at the edge after index 11; done=1; bit 13 is ignored; match_count=2.
REQ-043 Pattern 1101/len4; bits 1,1,0,1 with 3 seq_valid=0 cycles between each -> one pulse; match_count=1.
REQ-044 cfg_len=1 then start -> err_cfg=1, state_out=3; then cfg_we with len=3 -> IDLE.
REQ-045 Mid-run stop coinciding with a matching bit -> no pulse and IDLE; mid-run rst -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector. It counts matches of a programmable bit pattern
// in an input bit stream and ends a run when a target number of matches is reached.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               seq_valid,
  input  logic               seq_in,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic [1:0]         state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [3:0]         len_q;
  logic               ov_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [3:0]         fill_q;

  logic               cfg_open;
  logic               cfg_legal;
  logic               start_run;
  logic               sample;
  logic               hit;
  logic               reach;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [3:0]         fill_inc;
  logic [CNT_W-1:0]   count_inc;

  // Configuration is only writable while no run is in progress.
  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_ERR);
  assign cfg_legal = (len_q >= 4'd2) && ({1'b0, len_q} <= MAX_LEN_W) && (tgt_q != '0);
  assign start_run = start && !stop && cfg_legal &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  // stop discards a bit arriving in the same cycle, so it also suppresses a match.
  assign sample     = (state_q == S_RUN) && seq_valid && !stop;
  assign hist_shift = {hist_q[MAX_LEN-2:0], seq_in};
  assign fill_inc   = (fill_q < len_q) ? fill_q + 4'd1 : fill_q;
  assign count_inc  = match_count + CNT_W'(1);

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_q));
  end

  assign hit   = sample && (fill_inc == len_q) &&
                 ((hist_shift & len_mask) == (pat_q & len_mask));
  assign reach = hit && (count_inc == tgt_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order of statements.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (start) state_d = cfg_legal ? S_RUN : S_ERR;
        S_RUN:          if (reach) state_d = S_DONE;
        S_ERR:          if (cfg_we) state_d = S_IDLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    err_cfg   = (state_q == S_ERR);
    state_out = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= MAX_LEN'(3'b101);
      len_q <= 4'd3;
      ov_q  <= 1'b0;
      tgt_q <= CNT_W'(1);
    end else if (cfg_we && cfg_open) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ov_q  <= cfg_overlap;
      tgt_q <= cfg_target;
    end
  end

  // NOTE: the history is a plain shift register rather than a memory, so it
  // is reset together with the other datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= '0;
      fill_q      <= '0;
      match_count <= '0;
      detected    <= 1'b0;
    end else begin
      detected <= hit;
      if (start_run) begin
        hist_q      <= '0;
        fill_q      <= '0;
        match_count <= '0;
      end else if (sample) begin
        hist_q <= hist_shift;
        if (hit) begin
          match_count <= count_inc;
          fill_q      <= ov_q ? len_q : 4'd0;
        end else begin
          fill_q <= fill_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random traffic, checked by a
// window-based reference model and a scoreboard of expected detection pulses.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst, cfg_we, cfg_overlap, start, stop, seq_valid, seq_in;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               detected, busy, done, err_cfg;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state_out;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .seq_valid(seq_valid), .seq_in(seq_in),
    .detected(detected), .match_count(match_count), .busy(busy), .done(done),
    .err_cfg(err_cfg), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct { int at_cyc; int cnt; } exp_t;
  exp_t sb[$];

  // Reference model: a window of the bits seen since the run began or since
  // the last non-overlapping match.
  int          m_state;
  int          m_cnt;
  bit          m_det;
  bit          m_bits[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ov;
  int          m_tgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_edge();
    bit acc, legal, matched;
    m_det = 1'b0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_bits.delete();
      m_pat = 8'b101; m_len = 3; m_ov = 1'b0; m_tgt = 1;
      return;
    end
    acc   = cfg_we && (m_state == 0 || m_state == 3);
    legal = (m_len >= 2) && (m_len <= MAX_LEN) && (m_tgt != 0);
    if (stop) m_state = 0;
    else begin
      case (m_state)
        0, 2: if (start) begin
          if (legal) begin m_state = 1; m_cnt = 0; m_bits.delete(); end
          else m_state = 3;
        end
        1: if (seq_valid) begin
          m_bits.push_back(seq_in);
          if (m_bits.size() > m_len) void'(m_bits.pop_front());
          matched = (m_bits.size() == m_len);
          for (int i = 0; i < m_len && matched; i++)
            if (m_bits[m_bits.size()-1-i] != m_pat[i]) matched = 1'b0;
          if (matched) begin
            m_cnt++;
            m_det = 1'b1;
            sb.push_back('{cyc + 1, m_cnt});
            if (!m_ov) m_bits.delete();
            if (m_cnt == m_tgt) m_state = 2;
          end
        end
        default: if (cfg_we) m_state = 0;
      endcase
    end
    if (acc) begin
      m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap; m_tgt = cfg_target;
    end
  endfunction

  // Monitor: every detection pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (detected === 1'b1) begin
      if (sb.size() == 0) check("det_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("det_cycle", cyc, e.at_cyc);
        check("det_count", match_count, e.cnt);
      end
    end
  end

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    rst = 0; cfg_we = 0; start = 0; stop = 0; seq_valid = 0; seq_in = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_state"}, state_out, m_state);
    check({tag, "_count"}, match_count, m_cnt);
    check({tag, "_busy"}, busy, m_state == 1);
    check({tag, "_done"}, done, m_state == 2);
    check({tag, "_err"}, err_cfg, m_state == 3);
    check({tag, "_det"}, detected, m_det);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t; cfg_we = 1;
    tick();
  endtask

  task automatic do_stop();  stop = 1;  tick(); endtask
  task automatic do_start(); start = 1; tick(); endtask

  task automatic send_bit(input logic b);
    seq_valid = 1; seq_in = b;
    tick();
  endtask

  task automatic send_stream();
    logic [13:0] s;
    s = 14'b00110001010101;
    for (int i = 0; i < 14; i++) send_bit(s[13-i]);
  endtask

  task automatic random_cfg();
    cfg_pattern = 8'($urandom);
    cfg_len     = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 15));
    cfg_overlap = 1'($urandom_range(0, 1));
    cfg_target  = ($urandom_range(0, 9) < 9) ? 8'($urandom_range(1, 4)) : 8'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; cfg_we = 0; start = 0; stop = 0; seq_valid = 0; seq_in = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
    m_state = 0; m_cnt = 0; m_det = 0; m_pat = 8'b101; m_len = 3; m_ov = 0; m_tgt = 1;
    @(negedge clk);
    tick();
    check_outputs("reset");

    // Non-overlapping 101, two matches, run continues
    do_cfg(8'b101, 4'd3, 1'b0, 8'd8);
    do_start();
    send_stream();
    check_outputs("nonov");
    check("nonov_cnt2", match_count, 2);
    check("nonov_busy", busy, 1);
    drain("nonov");

    // Overlapping 101, three matches
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b1, 8'd8);
    do_start();
    send_stream();
    check("ov_cnt3", match_count, 3);
    check_outputs("ov");
    drain("ov");

    // Target 2 reached mid-stream; later bits ignored in DONE
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b1, 8'd2);
    do_start();
    send_stream();
    check("tgt_done", done, 1);
    check("tgt_cnt2", match_count, 2);
    check_outputs("tgt");
    drain("tgt");

    // Pattern spread over seq_valid gaps
    do_stop();
    do_cfg(8'b1101, 4'd4, 1'b0, 8'd8);
    do_start();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] p;
      p = 4'b1101;
      send_bit(p[3-i]);
      for (int g = 0; g < 3; g++) tick();
    end
    check("gap_cnt1", match_count, 1);
    check_outputs("gap");
    drain("gap");

    // Illegal length leads to ERR, a config write recovers
    do_stop();
    do_cfg(8'b101, 4'd1, 1'b0, 8'd1);
    do_start();
    check("err_flag", err_cfg, 1);
    check("err_state", state_out, 3);
    do_cfg(8'b101, 4'd3, 1'b0, 8'd1);
    check("err_recover", state_out, 0);
    check_outputs("err");

    // stop coinciding with the completing bit
    do_cfg(8'b101, 4'd3, 1'b0, 8'd8);
    do_start();
    send_bit(1); send_bit(0);
    stop = 1; seq_valid = 1; seq_in = 1;
    tick();
    check("stop_state", state_out, 0);
    check("stop_cnt", match_count, 0);
    check_outputs("stop");
    drain("stop");

    // Mid-run reset, then a run on the reset configuration
    do_start();
    send_bit(1); send_bit(0); send_bit(1);
    send_bit(1);
    rst = 1; start = 1; seq_valid = 1; seq_in = 1;
    tick();
    check_outputs("rst");
    check("rst_cnt0", match_count, 0);
    do_start();
    send_bit(1); send_bit(0); send_bit(1);
    check("rstcfg_done", done, 1);
    check("rstcfg_cnt", match_count, 1);
    check_outputs("rstcfg");
    drain("rstcfg");

    // Random traffic
    for (int run = 0; run < 40; run++) begin
      do_stop();
      random_cfg();
      cfg_we = 1;
      tick();
      do_start();
      for (int c = 0; c < 50; c++) begin
        seq_valid = ($urandom_range(0, 9) < 7);
        seq_in    = 1'($urandom_range(0, 1));
        stop      = ($urandom_range(0, 99) < 2);
        start     = ($urandom_range(0, 99) < 4);
        cfg_we    = ($urandom_range(0, 99) < 5);
        rst       = ($urandom_range(0, 199) == 0);
        random_cfg();
        tick();
        check_outputs("rand");
      end
      drain("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
